// File: rtl/add_sched_if.sv
// Request/response bundle for add_sched: four packed requesters on the request side,
// one valid/ready response channel back to a single consumer.
interface add_sched_if #(
    parameter int unsigned WIDTH = 4
);
    logic [3:0]         req_valid;
    logic [4*WIDTH-1:0] req_a;
    logic [4*WIDTH-1:0] req_b;
    logic [3:0]         req_cin;
    logic [3:0]         req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [1:0]         rsp_id;
    logic [WIDTH-1:0]   rsp_sum;
    logic               rsp_cout;

    // Requesters and consumer side
    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/add_sched.sv
// add_sched: round-robin scheduler sharing one WIDTH-bit adder among four requesters.
// Each operation takes IDLE (grant) -> EXEC (add) -> RESP (hold until consumed).
// Optional feature: define ADD_SCHED_PERF_EN to add the op_count completed-response counter.
module add_sched #(
    parameter int unsigned WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    add_sched_if.slave  bus
`ifdef ADD_SCHED_PERF_EN
    ,
    output logic [15:0] op_count
`endif
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic             op_cin_q;
    logic [1:0]       op_id_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             any_valid;
    logic             grant;
    logic [1:0]       win_id;
    logic [WIDTH:0]   add_res;
    logic             rsp_valid;

    // Round-robin search: walk offsets high to low so the lowest offset from ptr wins
    always_comb begin
        win_id    = ptr_q;
        any_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req_valid[ptr_q + 2'(k)]) begin
                win_id    = ptr_q + 2'(k);
                any_valid = 1'b1;
            end
        end
    end

    // Next-state, grant and pointer update
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant   = 1'b0;
        case (state_q)
            StIdle: begin
                if (any_valid) begin
                    state_d = StExec;
                    grant   = 1'b1;
                    ptr_d   = win_id + 2'd1;
                end
            end
            StExec:  state_d = StResp;
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A grant during reset would be silently lost, so suppress it at the source
        if (rst) begin
            grant = 1'b0;
        end
    end

    // FSM state and arbitration pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Capture the winner's operands on the grant edge; requester inputs are free afterwards
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_cin_q <= 1'b0;
            op_id_q  <= 2'd0;
        end else if (grant) begin
            op_a_q   <= bus.req_a[win_id*WIDTH +: WIDTH];
            op_b_q   <= bus.req_b[win_id*WIDTH +: WIDTH];
            op_cin_q <= bus.req_cin[win_id];
            op_id_q  <= win_id;
        end
    end

    assign add_res = {1'b0, op_a_q} + {1'b0, op_b_q} + {{WIDTH{1'b0}}, op_cin_q};

    // Register the shared adder result at the end of EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (state_q == StExec) begin
            sum_q  <= add_res[WIDTH-1:0];
            cout_q <= add_res[WIDTH];
        end
    end

    // Gated by rst so a reset cycle never presents a grant or a consumable response
    assign rsp_valid     = (state_q == StResp) && !rst;
    assign bus.rsp_valid = rsp_valid;
    assign bus.req_ready = grant ? (4'b0001 << win_id) : 4'b0000;
    assign bus.rsp_id    = op_id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;

`ifdef ADD_SCHED_PERF_EN
    // Completed-response counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= 16'd0;
        end else if (rsp_valid && bus.rsp_ready) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_add_sched.sv
// Bench for add_sched: table-driven single transactions, hand sequences for fairness,
// backpressure and mid-operation reset, then randomized traffic against a transaction model.
module tb_add_sched;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst;
`ifdef ADD_SCHED_PERF_EN
    logic [15:0] op_count;
`endif

    add_sched_if #(.WIDTH(W)) bus ();

    add_sched #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ADD_SCHED_PERF_EN
        ,
        .op_count (op_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] valid;
        logic [1:0] id;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] exp_ready;
        logic [1:0] exp_id;
        logic [3:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs [6];

    int gid [$];
    int gcyc [$];
    int exp_order [5] = '{0, 1, 2, 3, 0};

    // Transaction model state
    int m_ptr, m_busy, m_age, m_id, m_sum, m_cout, m_ops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic c);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_cin[i]      = c;
    endtask

    task automatic scramble();
        bus.req_a   = 16'($urandom);
        bus.req_b   = 16'($urandom);
        bus.req_cin = 4'($urandom);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = 4'b0;
        bus.rsp_ready = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        scramble();
        set_op(int'(v.id), v.a, v.b, v.cin);
        bus.req_valid = v.valid;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d grant", n), 32'(bus.req_ready), 32'(v.exp_ready));
        chk($sformatf("v%0d idle_rsp_valid", n), 32'(bus.rsp_valid), 0);
        next_cycle();
        bus.req_valid = 4'b0;
        scramble();
        @(negedge clk);
        chk($sformatf("v%0d exec_ready", n), 32'(bus.req_ready), 0);
        chk($sformatf("v%0d exec_rsp_valid", n), 32'(bus.rsp_valid), 0);
        next_cycle();
        @(negedge clk);
        chk($sformatf("v%0d rsp_valid", n), 32'(bus.rsp_valid), 1);
        chk($sformatf("v%0d rsp_id", n), 32'(bus.rsp_id), 32'(v.exp_id));
        chk($sformatf("v%0d rsp_sum", n), 32'(bus.rsp_sum), 32'(v.exp_sum));
        chk($sformatf("v%0d rsp_cout", n), 32'(bus.rsp_cout), 32'(v.exp_cout));
        next_cycle();
    endtask

    initial begin
        //          valid    id    a      b      cin   ready    id    sum    cout
        vecs[0] = {4'b0001, 2'd0, 4'd3,  4'd5,  1'b1, 4'b0001, 2'd0, 4'd9,  1'b0};
        vecs[1] = {4'b0100, 2'd2, 4'd15, 4'd15, 1'b1, 4'b0100, 2'd2, 4'd15, 1'b1};
        vecs[2] = {4'b0010, 2'd1, 4'd8,  4'd8,  1'b0, 4'b0010, 2'd1, 4'd0,  1'b1};
        vecs[3] = {4'b1000, 2'd3, 4'd0,  4'd0,  1'b0, 4'b1000, 2'd3, 4'd0,  1'b0};
        vecs[4] = {4'b0001, 2'd0, 4'd7,  4'd1,  1'b0, 4'b0001, 2'd0, 4'd8,  1'b0};
        vecs[5] = {4'b1000, 2'd3, 4'd9,  4'd6,  1'b1, 4'b1000, 2'd3, 4'd0,  1'b1};

        // Reset state, with every requester asking during reset
        rst           = 1'b1;
        bus.rsp_ready = 1'b1;
        scramble();
        bus.req_valid = 4'hf;
        next_cycle();
        @(negedge clk);
        chk("rst req_ready", 32'(bus.req_ready), 0);
        chk("rst rsp_valid", 32'(bus.rsp_valid), 0);
        next_cycle();
        rst           = 1'b0;
        bus.req_valid = 4'b0;
        @(negedge clk);
        chk("rst rsp_id", 32'(bus.rsp_id), 0);
        chk("rst rsp_sum", 32'(bus.rsp_sum), 0);
        chk("rst rsp_cout", 32'(bus.rsp_cout), 0);
        chk("idle req_ready", 32'(bus.req_ready), 0);
        chk("idle rsp_valid", 32'(bus.rsp_valid), 0);
`ifdef ADD_SCHED_PERF_EN
        chk("rst op_count", 32'(op_count), 0);
`endif
        next_cycle();

        // Table-driven single transactions
        for (int n = 0; n < 6; n++) begin
            run_vec(vecs[n], n);
        end

        // Fairness with all four requesters held
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_op(i, 4'(i), 4'd1, 1'b0);
        end
        bus.req_valid = 4'hf;
        bus.rsp_ready = 1'b1;
        begin
            int last;
            last = -1;
            for (int c = 0; c < 15; c++) begin
                @(negedge clk);
                if (bus.req_ready != 4'b0) begin
                    chk("fair onehot", 32'($countones(bus.req_ready)), 1);
                    for (int j = 0; j < 4; j++) begin
                        if (bus.req_ready[j]) begin
                            last = j;
                        end
                    end
                    gid.push_back(last);
                    gcyc.push_back(c);
                end
                if (bus.rsp_valid) begin
                    chk("fair rsp_sum", 32'(bus.rsp_sum), 32'(last + 1));
                end
                next_cycle();
            end
        end
        chk("fair grant_count", 32'(gid.size()), 5);
        for (int k = 0; k < 5 && k < gid.size(); k++) begin
            chk($sformatf("fair order%0d", k), 32'(gid[k]), 32'(exp_order[k]));
            if (k > 0) begin
                chk($sformatf("fair spacing%0d", k), 32'(gcyc[k] - gcyc[k-1]), 3);
            end
        end

        // Backpressure: hold RESP for five cycles while others are waiting
        do_reset();
        set_op(1, 4'd2, 4'd3, 1'b0);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp grant", 32'(bus.req_ready), 32'h2);
        next_cycle();
        bus.req_valid = 4'hf;
        @(negedge clk);
        chk("bp exec_ready", 32'(bus.req_ready), 0);
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d rsp_valid", c), 32'(bus.rsp_valid), 1);
            chk($sformatf("bp%0d rsp_id", c), 32'(bus.rsp_id), 1);
            chk($sformatf("bp%0d rsp_sum", c), 32'(bus.rsp_sum), 5);
            chk($sformatf("bp%0d req_ready", c), 32'(bus.req_ready), 0);
            next_cycle();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp release rsp_valid", 32'(bus.rsp_valid), 1);
        chk("bp release req_ready", 32'(bus.req_ready), 0);
        next_cycle();
        @(negedge clk);
        chk("bp idle rsp_valid", 32'(bus.rsp_valid), 0);
        chk("bp next grant", 32'(bus.req_ready), 32'h4);
        next_cycle();

        // Reset while in EXEC drops the operation
        do_reset();
        set_op(0, 4'd1, 4'd1, 1'b0);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("rstx grant", 32'(bus.req_ready), 32'h1);
        next_cycle();
        bus.req_valid = 4'b0;
        rst           = 1'b1;
        @(negedge clk);
        chk("rstx exec_valid", 32'(bus.rsp_valid), 0);
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rstx%0d no_rsp", c), 32'(bus.rsp_valid), 0);
            next_cycle();
        end
        set_op(3, 4'd4, 4'd4, 1'b0);
        bus.req_valid = 4'b1000;
        @(negedge clk);
        chk("rstx grant3", 32'(bus.req_ready), 32'h8);
        next_cycle();
        bus.req_valid = 4'b0;
        next_cycle();
        @(negedge clk);
        chk("rstx rsp_valid", 32'(bus.rsp_valid), 1);
        chk("rstx rsp_id", 32'(bus.rsp_id), 3);
        chk("rstx rsp_sum", 32'(bus.rsp_sum), 8);
        next_cycle();

`ifdef ADD_SCHED_PERF_EN
        // Performance counter
        do_reset();
        for (int n = 0; n < 3; n++) begin
            run_vec(vecs[n], 10 + n);
        end
        @(negedge clk);
        chk("perf op_count3", 32'(op_count), 3);
        next_cycle();
        do_reset();
        @(negedge clk);
        chk("perf op_count_rst", 32'(op_count), 0);
        next_cycle();
`endif

        // Randomized traffic against the transaction model
        do_reset();
        m_ptr  = 0;
        m_busy = 0;
        m_age  = 0;
        m_ops  = 0;
        for (int c = 0; c < 3000; c++) begin
            int win;
            int total;
            logic exp_valid;
            logic [3:0] exp_ready;
            rst           = ($urandom_range(0, 59) == 0);
            bus.req_valid = 4'($urandom);
            scramble();
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            win = -1;
            if (!rst && m_busy == 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (win < 0 && bus.req_valid[(m_ptr + k) % 4]) begin
                        win = (m_ptr + k) % 4;
                    end
                end
            end
            exp_ready = (win >= 0) ? 4'(1 << win) : 4'b0;
            exp_valid = !rst && m_busy != 0 && m_age == 2;
            chk("rnd req_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("rnd rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("rnd rsp_id", 32'(bus.rsp_id), 32'(m_id));
                chk("rnd rsp_sum", 32'(bus.rsp_sum), 32'(m_sum));
                chk("rnd rsp_cout", 32'(bus.rsp_cout), 32'(m_cout));
            end
`ifdef ADD_SCHED_PERF_EN
            chk("rnd op_count", 32'(op_count), 32'(m_ops % 65536));
`endif
            // Model update for the coming edge
            if (rst) begin
                m_busy = 0;
                m_ptr  = 0;
                m_ops  = 0;
            end else if (win >= 0) begin
                total  = int'(bus.req_a[win*W +: W]) + int'(bus.req_b[win*W +: W])
                       + int'(bus.req_cin[win]);
                m_busy = 1;
                m_age  = 1;
                m_ptr  = (win + 1) % 4;
                m_id   = win;
                m_sum  = total % 16;
                m_cout = (total >= 16) ? 1 : 0;
            end else if (m_busy != 0 && m_age == 1) begin
                m_age = 2;
            end else if (exp_valid && bus.rsp_ready) begin
                m_busy = 0;
                m_ops++;
            end
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_sched.md
ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 Parameter WIDTH, default 4, operand and sum width in bits.
REQ-002 The requester count SHALL be fixed at 4, with IDs 0..3.
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk only.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 req_valid  input  4  per-requester operation request; bit i belongs to requester i.
REQ-006 req_a  input  4*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
REQ-007 req_b  input  4*WIDTH  operand B, packed the same way as req_a.
REQ-008 req_cin  input  4  per-requester carry-in.
REQ-009 req_ready  output  4  one-hot grant; bit i high means requester i's operation is accepted this cycle.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  consumer accepts the result.
REQ-012 rsp_id  output  2  ID of the requester that owns the result.
REQ-013 rsp_sum  output  WIDTH  sum of the granted operation.
REQ-014 rsp_cout  output  1  carry-out of the granted operation.

Function
REQ-015 A three-state FSM SHALL be used:
- IDLE: arbitrate.
- EXEC: shared adder computes.
- RESP: hold the result.
REQ-016 IDLE SHALL go to EXEC when any req_valid bit is high, and stay in IDLE otherwise.
REQ-017 EXEC SHALL always go to RESP after exactly one cycle.
REQ-018 RESP SHALL go to IDLE when rsp_ready is high, and stay in RESP otherwise.
REQ-019 req_ready SHALL be nonzero only in IDLE, and only in the cycle the FSM leaves IDLE.
REQ-020 In that cycle exactly one req_ready bit SHALL be high: the winning requester's.
REQ-021 Arbitration SHALL be round-robin:
- Priority starts at pointer ptr and proceeds ptr, ptr+1, ... mod 4.
- After a grant to requester g, ptr SHALL become (g+1) mod 4.
- ptr SHALL NOT change when nothing is granted.
REQ-022 On the grant edge, the winner's A, B, cin and ID SHALL be captured into internal operand registers.
- Requester inputs are don't-care after the grant.
REQ-023 In EXEC, {cout,sum} SHALL be computed as a WIDTH+1-bit sum A+B+cin and registered at the end of EXEC.
- Overflow is reported only through cout; there is no wrap detection.
REQ-024 Latency: grant in cycle N SHALL give rsp_valid high from cycle N+2.
REQ-025 rsp_valid SHALL be high only in RESP.
REQ-026 rsp_id, rsp_sum and rsp_cout SHALL be stable while rsp_valid is high.
REQ-027 Handshake: a result is consumed in the cycle where rsp_valid and rsp_ready are both high.
- The next grant can occur no earlier than the following cycle.
- Peak throughput is 1 operation per 3 cycles.
REQ-028 A requester SHALL hold req_valid and its operands until granted.
- Deasserting req_valid before grant SHALL be legal and removes that requester from arbitration.
REQ-029 rsp_ready high outside RESP SHALL be ignored.
REQ-030 A requester that raises req_valid again in the cycle after its own response SHALL compete normally under the current ptr.

Reset
REQ-031 On rst the block SHALL reset to:
- FSM = IDLE, ptr = 0.
- req_ready = 0, rsp_valid = 0.
- rsp_id = 0, rsp_sum = 0, rsp_cout = 0.
- Operand registers = 0.
REQ-032 On rst asserted in EXEC or RESP:
- The in-flight operation SHALL be dropped, with no response issued.
- No grant SHALL occur in a cycle where rst is high.
REQ-033 After rst deasserts, the first grant SHALL be possible in the first cycle with rst low.

Configuration
REQ-034 Macro ADD_SCHED_PERF_EN controls a performance counter.
REQ-035 With ADD_SCHED_PERF_EN defined, the block SHALL add output op_count [15:0] that counts completed responses.
- op_count increments on each rsp_valid&rsp_ready cycle.
- op_count wraps 65535->0.
- op_count resets to 0 on rst.
REQ-036 Without ADD_SCHED_PERF_EN, the op_count port and its logic SHALL be absent, with no other behavioural change.

Verification (WIDTH=4)
REQ-037 Single request: req_valid=0001, a0=3, b0=5, cin0=1, rsp_ready=1 -> req_ready=0001 in cycle N; rsp_valid in N+2 with id=0, sum=9, cout=0.
REQ-038 Overflow: a=15, b=15, cin=1 on requester 2 -> rsp_id=2, rsp_sum=15, rsp_cout=1.
REQ-039 Fairness: req_valid=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0, with a grant every 3 cycles.
REQ-040 Backpressure: rsp_ready=0 for 5 cycles while in RESP -> rsp_valid and data held, req_ready stays 0, no new grant; raising rsp_ready -> IDLE next cycle.
REQ-041 Reset mid-operation: rst pulse in EXEC -> no rsp_valid afterwards; next req_valid=1000 is granted to requester 3 (ptr=0, only requester 3 pending).
REQ-042 With ADD_SCHED_PERF_EN defined: 3 completed responses -> op_count=3; rst -> op_count=0.
